// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package fetch_pkg;

    typedef enum logic {
        ST_REQ  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions of the {N,C,Z,V} flags inside conditional_flags.
    localparam int FLAG_N = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/fetch_sequencer_branch_cond_eval.sv
// Evaluates a 4-bit branch condition code against the {N,C,Z,V} flags.
// Latency: purely combinational.
// Backpressure: none.
module branch_cond_eval
    import fetch_pkg::*;
(
    input  logic [3:0] br_cond,
    input  logic [3:0] conditional_flags,
    output logic       cond_true
);

    logic flag_n;
    logic flag_c;
    logic flag_z;
    logic flag_v;

    assign flag_n = conditional_flags[FLAG_N];
    assign flag_c = conditional_flags[FLAG_C];
    assign flag_z = conditional_flags[FLAG_Z];
    assign flag_v = conditional_flags[FLAG_V];

    always_comb begin
        cond_true = 1'b0;
        case (br_cond)
            COND_EQ: cond_true = flag_z;
            COND_NE: cond_true = ~flag_z;
            COND_CS: cond_true = flag_c;
            COND_CC: cond_true = ~flag_c;
            COND_MI: cond_true = flag_n;
            COND_PL: cond_true = ~flag_n;
            COND_VS: cond_true = flag_v;
            COND_VC: cond_true = ~flag_v;
            COND_HI: cond_true = flag_c & ~flag_z;
            COND_LS: cond_true = ~(flag_c & ~flag_z);
            COND_GE: cond_true = (flag_n == flag_v);
            COND_LT: cond_true = (flag_n != flag_v);
            COND_GT: cond_true = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_true = flag_z | (flag_n != flag_v);
            COND_AL: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer with conditional branch redirect; FETCH_SEQ_STATS_EN adds fetch/redirect counters.
// Latency: instruction valid the cycle after imem_ack; one instruction per two cycles at best.
// Backpressure: holds the instruction (no new request) until instr_ready; a taken branch overrides both.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_valid,
    input  logic [3:0]  br_cond,
    input  logic [31:0] br_pc,
    input  logic [15:0] br_offset,
    input  logic [3:0]  conditional_flags,
    output logic [31:0] pc
`ifdef FETCH_SEQ_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
`endif
);

    fetch_state_e state;
    fetch_state_e state_nxt;
    logic [31:0]  pc_nxt;
    logic [31:0]  instr_nxt;
    logic [31:0]  br_target;
    logic         cond_true;
    logic         br_taken;
    logic         fetch_accept;

    branch_cond_eval u_cond (
        .br_cond           (br_cond),
        .conditional_flags (conditional_flags),
        .cond_true         (cond_true)
    );

    assign br_taken  = br_valid & cond_true;
    assign br_target = br_pc + {{16{br_offset[15]}}, br_offset};

    // An ack coinciding with a taken branch belongs to the wrong path and is dropped.
    assign fetch_accept = (state == ST_REQ) & imem_ack & ~br_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_REQ;
            pc          <= RESET_PC;
            instruction <= 32'h0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            instruction <= instr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        instr_nxt = instruction;
        if (br_taken) begin
            state_nxt = ST_REQ;
            pc_nxt    = br_target;
        end else begin
            case (state)
                ST_REQ: begin
                    if (imem_ack) begin
                        instr_nxt = imem_rdata;
                        pc_nxt    = pc + 32'd4;
                        state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (instr_ready) begin
                        state_nxt = ST_REQ;
                    end
                end
                default: state_nxt = ST_REQ;
            endcase
        end
    end

    // Request is gated by reset so nothing is issued while the block is held.
    assign imem_req    = (state == ST_REQ) & ~reset;
    assign imem_addr   = pc;
    assign instr_valid = (state == ST_HOLD);

`ifdef FETCH_SEQ_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count    <= 32'h0;
            redirect_count <= 32'h0;
        end else begin
            if (fetch_accept) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (br_taken) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`else
    logic unused_accept;
    assign unused_accept = fetch_accept;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: reference model checked every cycle plus directed literal checks.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_valid;
    logic [3:0]  br_cond;
    logic [31:0] br_pc;
    logic [15:0] br_offset;
    logic [3:0]  conditional_flags;
    logic [31:0] pc;
`ifdef FETCH_SEQ_STATS_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .instruction       (instruction),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .br_valid          (br_valid),
        .br_cond           (br_cond),
        .br_pc             (br_pc),
        .br_offset         (br_offset),
        .conditional_flags (conditional_flags),
        .pc                (pc)
`ifdef FETCH_SEQ_STATS_EN
        ,
        .fetch_count       (fetch_count),
        .redirect_count    (redirect_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    always_comb imem_rdata = imem_addr ^ 32'h5A5A_0000;

    int n_chk = 0;
    int n_bad = 0;
    bit check_en = 0;

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // ARM-style evaluation: the upper three bits select a base test, bit 0 inverts it.
    function automatic bit cond_model(input logic [3:0] c, input logic [3:0] f);
        bit n, cf, z, v, base;
        n = f[3]; cf = f[2]; z = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cf;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cf && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_busy;
    int unsigned m_fetch;
    int unsigned m_redir;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_busy = 0; m_fetch = 0; m_redir = 0;
        end else if (br_valid && cond_model(br_cond, conditional_flags)) begin
            m_pc = br_pc + 32'($signed(br_offset));
            m_busy = 0;
            m_redir++;
        end else if (!m_busy && imem_ack) begin
            m_instr = imem_rdata;
            m_pc = m_pc + 32'd4;
            m_busy = 1;
            m_fetch++;
        end else if (m_busy && instr_ready) begin
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            cmp("m_imem_req", imem_req, !reset && !m_busy);
            if (!reset && !m_busy) cmp("m_imem_addr", imem_addr, m_pc);
            cmp("m_pc", pc, m_pc);
            cmp("m_instr_valid", instr_valid, m_busy);
            cmp("m_instruction", instruction, m_instr);
`ifdef FETCH_SEQ_STATS_EN
            cmp("m_fetch_count", fetch_count, m_fetch);
            cmp("m_redirect_count", redirect_count, m_redir);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic branch(input logic [3:0] c, input logic [3:0] f,
                          input logic [31:0] bpc, input logic [15:0] off);
        br_valid = 1'b1; br_cond = c; conditional_flags = f; br_pc = bpc; br_offset = off;
    endtask

    logic [31:0] addrs[$];
    logic [31:0] instrs[$];
    logic [7:0]  vpat;
    logic [15:0] dut_mask[16];
    logic [15:0] mod_mask;
    logic [15:0] lit_mask;
    logic [31:0] tgt;

    initial begin
        reset = 1; imem_ack = 0; instr_ready = 0;
        br_valid = 0; br_cond = 0; br_pc = 0; br_offset = 0; conditional_flags = 0;
        tick();
        check_en = 1;
        tick();
        cmp("rst_imem_req", imem_req, 1'b0);
        cmp("rst_pc", pc, 32'h0);
        cmp("rst_instr_valid", instr_valid, 1'b0);
        cmp("rst_instruction", instruction, 32'h0);

        // Streaming with ack tied high and ready high.
        reset = 0; imem_ack = 1; instr_ready = 1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick(); else #1;
            vpat[i] = instr_valid;
            if (imem_req) addrs.push_back(imem_addr);
            if (instr_valid) instrs.push_back(instruction);
        end
        cmp("stream_vpat", vpat, 8'b1010_1010);
        cmp("stream_nreq", addrs.size(), 4);
        cmp("stream_ninstr", instrs.size(), 4);
        for (int i = 0; i < 4 && i < addrs.size() && i < instrs.size(); i++) begin
            cmp("stream_addr", addrs[i], 32'(i * 4));
            cmp("stream_instr", instrs[i], 32'h5A5A_0000 | 32'(i * 4));
        end

        // Downstream stall for three cycles while holding.
        instr_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp("stall_instr", instruction, 32'h5A5A_000C);
            cmp("stall_req", imem_req, 1'b0);
            cmp("stall_pc", pc, 32'h10);
        end
        instr_ready = 1; imem_ack = 0;
        tick();
        cmp("release_req", imem_req, 1'b1);
        cmp("release_addr", imem_addr, 32'h10);
        instr_ready = 0;

        // EQ branch: move away first, then not-taken, then taken backwards.
        branch(4'hE, 4'h0, 32'h100, 16'h0040);
        tick();
        cmp("al_pc", pc, 32'h140);
        branch(4'h0, 4'b0000, 32'h20, 16'hFFF0);
        tick();
        cmp("eq_nt_pc", pc, 32'h140);
        branch(4'h0, 4'b0010, 32'h20, 16'hFFF0);
        tick();
        br_valid = 0;
        #1;
        cmp("eq_t_addr", imem_addr, 32'h10);
        cmp("eq_t_req", imem_req, 1'b1);

        // Branch and ack in the same cycle: ack data dropped.
        imem_ack = 1;
        branch(4'hE, 4'h0, 32'h200, 16'h8000);
        tick();
        br_valid = 0; imem_ack = 0;
        #1;
        cmp("coll_valid", instr_valid, 1'b0);
        cmp("coll_addr", imem_addr, 32'hFFFF_8200);
        cmp("coll_instr", instruction, 32'h5A5A_000C);

        // pc wrap on increment.
        branch(4'hE, 4'h0, 32'hFFFF_FFF8, 16'h0004);
        tick();
        br_valid = 0; imem_ack = 1; instr_ready = 1;
        cmp("wrap_pre_pc", pc, 32'hFFFF_FFFC);
        tick();
        cmp("wrap_pc", pc, 32'h0);
        cmp("wrap_instr", instruction, 32'hA5A5_FFFC);
        imem_ack = 0;
        tick();
        imem_ack = 1; instr_ready = 0;
        tick();
        cmp("hold_valid_pre", instr_valid, 1'b1);

        // Taken branch while holding.
        imem_ack = 0;
        branch(4'hE, 4'h0, 32'h300, 16'h0000);
        tick();
        br_valid = 0;
        #1;
        cmp("hold_br_valid", instr_valid, 1'b0);
        cmp("hold_br_pc", pc, 32'h300);
        cmp("hold_br_req", imem_req, 1'b1);

        // Condition sweep: 16 codes x 16 flag values.
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                tgt = 32'h0001_0000 + 32'((c * 16 + f) * 16) + 32'd4;
                branch(4'(c), 4'(f), tgt - 32'd4, 16'h0004);
                tick();
                dut_mask[c][f] = (pc == tgt);
            end
        end
        br_valid = 0;
        for (int c = 0; c < 16; c++) begin
            mod_mask = '0;
            for (int f = 0; f < 16; f++) mod_mask[f] = cond_model(4'(c), 4'(f));
            cmp("sweep_mask_model", dut_mask[c], mod_mask);
            lit_mask = 16'h0;
            case (c)
                0:  lit_mask = 16'hCCCC;
                1:  lit_mask = 16'h3333;
                2:  lit_mask = 16'hF0F0;
                4:  lit_mask = 16'hFF00;
                6:  lit_mask = 16'hAAAA;
                10: lit_mask = 16'hAA55;
                14: lit_mask = 16'hFFFF;
                15: lit_mask = 16'h0000;
                default: lit_mask = mod_mask;
            endcase
            if (c inside {0, 1, 2, 4, 6, 10, 14, 15})
                cmp("sweep_mask_literal", dut_mask[c], lit_mask);
        end

        // Reset while requesting with ack low.
        reset = 1;
        tick();
        cmp("mid_rst_req", imem_req, 1'b0);
        cmp("mid_rst_pc", pc, 32'h0);
        cmp("mid_rst_valid", instr_valid, 1'b0);
        cmp("mid_rst_instr", instruction, 32'h0);
`ifdef FETCH_SEQ_STATS_EN
        cmp("mid_rst_fetch_count", fetch_count, 32'h0);
        cmp("mid_rst_redirect_count", redirect_count, 32'h0);
`endif
        imem_ack = 1;
        branch(4'hE, 4'h0, 32'h500, 16'h0000);
        tick();
        cmp("rst_ignore_pc", pc, 32'h0);
        cmp("rst_ignore_valid", instr_valid, 1'b0);
        br_valid = 0; imem_ack = 0; reset = 0;
        #1;
        cmp("post_rst_req", imem_req, 1'b1);
        cmp("post_rst_addr", imem_addr, 32'h0);
        imem_ack = 1; instr_ready = 1;
        tick();
        cmp("post_rst_valid", instr_valid, 1'b1);
        cmp("post_rst_instr", instruction, 32'h5A5A_0000);
        imem_ack = 0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning the fetch address loaded on reset.
REQ-002 clk  input  1  main clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 imem_req  output  1  instruction-memory read request, held until imem_ack.
REQ-005 imem_addr  output  32  read address; equals pc while imem_req=1.
REQ-006 imem_ack  input  1  memory response valid this cycle.
REQ-007 imem_rdata  input  32  instruction word; valid when imem_ack=1.
REQ-008 instruction  output  32  fetched instruction presented downstream.
REQ-009 instr_valid  output  1  instruction is valid.
REQ-010 instr_ready  input  1  downstream accepts instruction this cycle.
REQ-011 br_valid  input  1  execute stage presents a branch this cycle.
REQ-012 br_cond  input  4  condition code, 4'b0000..4'b1111.
REQ-013 br_pc  input  32  address of the branch instruction.
REQ-014 br_offset  input  16  signed byte offset.
REQ-015 conditional_flags  input  4  CPSR flags {N,C,Z,V} at bits [3:0].
REQ-016 pc  output  32  address of the next instruction to fetch.

Function
REQ-017 FSM states REQ and HOLD SHALL be implemented; REQ is the state after reset.
REQ-018 In REQ: imem_req=1 and imem_addr=pc; on imem_ack, instruction<=imem_rdata, instr_valid<=1, pc<=pc+4 and the next state is HOLD; without imem_ack the FSM stays in REQ with the address stable.
REQ-019 In HOLD: instr_valid=1 and imem_req=0; on instr_ready, instr_valid<=0 and the next state is REQ; otherwise instruction is held unchanged.
REQ-020 Branch taken = br_valid & cond_true, using this condition map: 0 Z; 1 !Z; 2 C; 3 !C; 4 N; 5 !N; 6 V; 7 !V; 8 C&!Z; 9 !(C&!Z); A N==V; B N!=V; C !Z&(N==V); D Z|(N!=V); E always; F never (nop).
REQ-021 On branch taken: pc <= br_pc + sign-extended br_offset (modulo 2^32), instr_valid<=0 and the next state is REQ, regardless of the current state.
REQ-022 Branch taken SHALL have priority over imem_ack and instr_ready in the same cycle; imem_rdata acked in that cycle is discarded and pc is not incremented.
REQ-023 Branch not taken SHALL have no effect on any state.
REQ-024 pc wraps from 32'hFFFF_FFFC to 32'h0000_0000 on increment; no alignment check is performed.
REQ-025 Sustained throughput is one instruction per two cycles when imem_ack returns in the request cycle and instr_ready=1.

Reset
REQ-026 While reset=1: pc=RESET_PC, instruction=32'h0, instr_valid=0, imem_req=0, state=REQ; imem_ack, br_valid and instr_ready are ignored.
REQ-027 The first request SHALL be issued in the first cycle after reset deasserts, with imem_addr=RESET_PC.
REQ-028 Reset asserted mid-transaction SHALL abandon the outstanding request; no stale data is delivered.

Configuration
REQ-029 With FETCH_SEQ_STATS_EN defined, the block SHALL add outputs fetch_count[31:0] (incremented per accepted imem_ack not discarded) and redirect_count[31:0] (incremented per branch taken), both cleared by reset and wrapping at 2^32.
REQ-030 Without FETCH_SEQ_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state enum, the 4-bit condition-code constants (COND_EQ..COND_NV) and the flag bit indices (FLAG_N=3, FLAG_C=2, FLAG_Z=1, FLAG_V=0).
REQ-032 The combinational sub-module branch_cond_eval (inputs br_cond and conditional_flags, output cond_true) SHALL implement REQ-020.

Verification
REQ-033 Reset release with RESET_PC=0 and imem_ack tied high: imem_addr sequence 0,4,8,C; instruction values match memory; instr_valid toggles 1 cycle on, 1 cycle off.
REQ-034 instr_ready held low for 3 cycles in HOLD: instruction stable, imem_req=0 and pc unchanged until instr_ready=1.
REQ-035 br_valid, br_cond=0 (EQ), flags=4'b0010, br_pc=0x20, br_offset=16'hFFF0: next imem_addr=0x10; with flags=4'b0000 pc is unchanged.
REQ-036 Branch taken in the same cycle as imem_ack: ack data is discarded, instr_valid stays 0 and the next imem_addr is the branch target.
REQ-037 Sweep all 16 br_cond codes against all 16 flag values: taken/not-taken matches REQ-020; code F is never taken and code E is always taken.
REQ-038 Reset asserted while in REQ with imem_ack low: the next cycle shows imem_req=0, pc=RESET_PC and instr_valid=0; with FETCH_SEQ_STATS_EN defined, both counters read 0.
